multicycle_control: RTL and testbench



---
 rtl/multicycle_control.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Main control FSM for a multicycle 16-bit processor. It sequences fetch,
//   decode, execute, memory and write-back. It produces the datapath strobes
//   from the current state and the instruction register, plus MemAck during
//   fetch. It also counts retired instructions.
//
// Ports
//   clk, rst_n    : clock (rising edge) and asynchronous active-low reset
//   Ins[15:0]     : instruction register ([15:11] opcode, [1:0] function)
//   Branch        : branch-condition result for Ins
//   MemAck        : memory transfer complete (only looked at in IF / MEM)
//   MemReq, IorD, MemWrite                   : memory interface control
//   IRWrite, PCWrite, PCSrc                  : IR / PC load control
//   RegWrite, FlagWrite, ALUop[2:0], OutEn   : datapath strobes
//   Halt          : processor halted (sticky until reset)
//   IllegalOp     : one-cycle pulse on an undefined opcode in ID
//   State[2:0]    : current FSM state code
//   RetireCnt[15:0]: retired-instruction counter, wraps
// ---------------------------------------------------------------------------
module multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Ins,
  input  logic        Branch,
  input  logic        MemAck,
  output logic        MemReq,
  output logic        IorD,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        FlagWrite,
  output logic [2:0]  ALUop,
  output logic        OutEn,
  output logic        Halt,
  output logic        IllegalOp,
  output logic [2:0]  State,
  output logic [15:0] RetireCnt
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  // Instruction classes; each one selects a distinct path through the FSM.
  typedef enum logic [3:0] {
    C_ALU,    // EX -> WB, no flag update
    C_ALUF,   // EX -> WB, flags written in EX
    C_CMP,    // EX only, flags written
    C_LOAD,   // EX -> MEM -> WB
    C_STORE,  // EX -> MEM
    C_BR,     // conditional PC load in EX
    C_JMP,    // unconditional PC load in EX
    C_JAL,    // PC load plus link write in EX
    C_OUT,    // output strobe in EX
    C_HLT,    // EX -> HALT
    C_ILL     // undefined opcode
  } cls_e;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_PASS = 3'd4;
  localparam logic [2:0] ALU_LHI  = 3'd5;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  state_e      state_q, state_d;
  logic [15:0] retire_cnt_q, retire_cnt_d;
  cls_e        cls;
  logic [2:0]  alu_sel;
  logic        retire;

  logic [4:0]  opcode;
  logic [1:0]  fn;
  logic        unused_ins;

  assign opcode     = Ins[15:11];
  assign fn         = Ins[1:0];
  // Branch condition and register fields belong to other units.
  assign unused_ins = ^Ins[10:2];

  // -------------------------------------------------------------------------
  // Opcode decode
  // -------------------------------------------------------------------------
  always_comb begin
    cls     = C_ILL;
    alu_sel = ALU_ADD;
    case (opcode)
      5'b00000: begin cls = C_ALUF; alu_sel = {1'b0, fn}; end  // ADD/ADC/SUB/SBB
      5'b00001: begin cls = C_ALU;  alu_sel = ALU_LHI;    end  // LHI
      5'b00010: begin cls = C_ALU;  alu_sel = ALU_PASS;   end  // LLI
      5'b00011: cls = C_LOAD;                                  // LDRri
      5'b00100: if (fn == 2'b00) cls = C_LOAD;                 // LDRrr
      5'b00101: cls = C_STORE;                                 // STRri
      5'b00110: begin
        if (fn == 2'b00) cls = C_STORE;                        // STRrr
        else if (fn == 2'b01) begin                            // CMP
          cls     = C_CMP;
          alu_sel = ALU_SUB;
        end
      end
      5'b00111: cls = C_ALUF;                                  // ADDI
      5'b01000: begin cls = C_ALUF; alu_sel = ALU_SUB;    end  // SUBI
      5'b01011: begin cls = C_ALU;  alu_sel = ALU_PASS;   end  // MOV
      5'b10000: cls = C_JMP;                                   // JMP
      5'b10001: cls = C_JAL;                                   // JALrl
      5'b10010: cls = C_JAL;                                   // JALrr
      5'b10011: cls = C_JMP;                                   // JR
      5'b11000: cls = C_BR;                                    // Bcc
      5'b11001: cls = C_BR;                                    // BAL
      5'b11100: begin
        if (fn == 2'b00)      cls = C_OUT;                     // OutR
        else if (fn == 2'b01) cls = C_HLT;                     // HLT
      end
      default: cls = C_ILL;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next state and retirement. The retire flag marks the last cycle of a
  // legal instruction.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IF:  if (MemAck) state_d = S_ID;
      S_ID:  state_d = (cls == C_ILL) ? S_IF : S_EX;
      S_EX: begin
        case (cls)
          C_ALU, C_ALUF:   state_d = S_WB;
          C_LOAD, C_STORE: state_d = S_MEM;
          C_HLT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          C_ILL:           state_d = S_IF;  // only if Ins changed after ID
          default: begin
            state_d = S_IF;
            retire  = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (MemAck) begin
          if (cls == C_STORE) begin
            state_d = S_IF;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;              // unused codes 6 and 7
    endcase
    retire_cnt_d = retire_cnt_q + {15'd0, retire};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IF;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from state and instruction. IRWrite/PCWrite in IF follow
  // MemAck so the fetch completes in the acknowledge cycle. Everything is
  // forced low while reset is held, so an IF state under reset does not
  // raise MemReq.
  // -------------------------------------------------------------------------
  always_comb begin
    MemReq    = 1'b0;
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    RegWrite  = 1'b0;
    FlagWrite = 1'b0;
    ALUop     = ALU_ADD;
    OutEn     = 1'b0;
    Halt      = 1'b0;
    IllegalOp = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IF: begin
          MemReq  = 1'b1;
          IRWrite = MemAck;
          PCWrite = MemAck;
        end
        S_ID: IllegalOp = (cls == C_ILL);
        S_EX: begin
          ALUop = alu_sel;
          case (cls)
            C_ALUF, C_CMP: FlagWrite = 1'b1;
            C_BR: begin
              PCSrc   = 1'b1;
              PCWrite = Branch;
            end
            C_JMP: begin
              PCSrc   = 1'b1;
              PCWrite = 1'b1;
            end
            C_JAL: begin
              PCSrc    = 1'b1;
              PCWrite  = 1'b1;
              RegWrite = 1'b1;   // link register gets the already-incremented PC
            end
            C_OUT:   OutEn = 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          MemReq   = 1'b1;
          IorD     = 1'b1;
          MemWrite = (cls == C_STORE);
        end
        S_WB:    RegWrite = 1'b1;
        S_HALT:  Halt = 1'b1;
        default: ;
      endcase
    end
  end

  assign State     = state_q;
  assign RetireCnt = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Scoreboard bench for multicycle_control. A driver task expands each
//   instruction into its expected per-cycle output list, using the
//   instruction-class rules and the chosen memory wait counts. It pushes that
//   list to a queue and drives the inputs cycle by cycle. A monitor pops one
//   expected record on every falling edge and compares it with the DUT
//   outputs.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] Ins = 16'h0;
  logic        Branch = 1'b0;
  logic        MemAck = 1'b0;
  logic        MemReq, IorD, MemWrite, IRWrite, PCWrite, PCSrc;
  logic        RegWrite, FlagWrite, OutEn, Halt, IllegalOp;
  logic [2:0]  ALUop, State;
  logic [15:0] RetireCnt;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Ins(Ins), .Branch(Branch), .MemAck(MemAck),
    .MemReq(MemReq), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .FlagWrite(FlagWrite), .ALUop(ALUop), .OutEn(OutEn), .Halt(Halt),
    .IllegalOp(IllegalOp), .State(State), .RetireCnt(RetireCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        mreq, iord, mwr, irw, pcw, pcsrc, rw, fw;
    logic [2:0]  alu;
    logic        oen, hlt, ill;
    logic [15:0] rc;
  } exp_t;

  localparam int K_ALU = 0, K_ALUF = 1, K_CMP = 2, K_LOAD = 3, K_STORE = 4,
                 K_BR = 5, K_JMP = 6, K_JAL = 7, K_OUT = 8, K_HLT = 9,
                 K_ILL = 10;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  bit          rel_pending = 1'b0;
  logic [15:0] mcnt = 16'h0;   // reference retirement count

  // Instruction set table: class and ALU operation per opcode/function.
  function automatic int classify(input logic [15:0] ins, output logic [2:0] alu);
    logic [4:0] op;
    logic [1:0] fn;
    op  = ins[15:11];
    fn  = ins[1:0];
    alu = 3'd0;
    case (op)
      5'd0:  begin alu = {1'b0, fn}; return K_ALUF; end
      5'd1:  begin alu = 3'd5; return K_ALU; end
      5'd2:  begin alu = 3'd4; return K_ALU; end
      5'd3:  return K_LOAD;
      5'd4:  return (fn == 2'd0) ? K_LOAD : K_ILL;
      5'd5:  return K_STORE;
      5'd6: begin
        if (fn == 2'd0) return K_STORE;
        if (fn == 2'd1) begin alu = 3'd2; return K_CMP; end
        return K_ILL;
      end
      5'd7:  return K_ALUF;
      5'd8:  begin alu = 3'd2; return K_ALUF; end
      5'd11: begin alu = 3'd4; return K_ALU; end
      5'd16, 5'd19: return K_JMP;
      5'd17, 5'd18: return K_JAL;
      5'd24, 5'd25: return K_BR;
      5'd28: begin
        if (fn == 2'd0) return K_OUT;
        if (fn == 2'd1) return K_HLT;
        return K_ILL;
      end
      default: return K_ILL;
    endcase
  endfunction

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e    = '0;
    e.st = st;
    e.rc = mcnt;
    return e;
  endfunction

  // Expand one instruction into expected cycles and drive it. ack codes:
  // 0/1 drive MemAck, 2 drives a random value (the DUT must ignore it).
  // stop_n > 0 truncates driving after that many cycles.
  task automatic run_instr(input logic [15:0] ins, input logic br, input int if_w,
                           input int mem_w, input int halt_n, input int stop_n);
    exp_t        recs[$];
    int          acks[$];
    exp_t        e;
    logic [2:0]  alu;
    int          k, n;
    k = classify(ins, alu);
    e = blank(3'd0); e.mreq = 1'b1;
    for (int w = 0; w < if_w; w++) begin recs.push_back(e); acks.push_back(0); end
    e.irw = 1'b1; e.pcw = 1'b1;
    recs.push_back(e); acks.push_back(1);
    e = blank(3'd1); e.ill = (k == K_ILL);
    recs.push_back(e); acks.push_back(2);
    if (k != K_ILL) begin
      e = blank(3'd2); e.alu = alu;
      if (k == K_ALUF || k == K_CMP) e.fw = 1'b1;
      if (k == K_BR) begin e.pcsrc = 1'b1; e.pcw = br; end
      if (k == K_JMP || k == K_JAL) begin e.pcsrc = 1'b1; e.pcw = 1'b1; end
      if (k == K_JAL) e.rw = 1'b1;
      if (k == K_OUT) e.oen = 1'b1;
      recs.push_back(e); acks.push_back(2);
      if (k inside {K_CMP, K_BR, K_JMP, K_JAL, K_OUT, K_HLT}) mcnt = mcnt + 16'd1;
      if (k == K_HLT) begin
        e = blank(3'd5); e.hlt = 1'b1;
        for (int h = 0; h < halt_n; h++) begin recs.push_back(e); acks.push_back(2); end
      end
      if (k == K_LOAD || k == K_STORE) begin
        e = blank(3'd3); e.mreq = 1'b1; e.iord = 1'b1; e.mwr = (k == K_STORE);
        for (int w = 0; w < mem_w; w++) begin recs.push_back(e); acks.push_back(0); end
        recs.push_back(e); acks.push_back(1);
        if (k == K_STORE) mcnt = mcnt + 16'd1;
      end
      if (k == K_ALU || k == K_ALUF || k == K_LOAD) begin
        e = blank(3'd4); e.rw = 1'b1;
        recs.push_back(e); acks.push_back(2);
        mcnt = mcnt + 16'd1;
      end
    end
    foreach (recs[i]) exp_q.push_back(recs[i]);
    n = (stop_n > 0 && stop_n < recs.size()) ? stop_n : recs.size();
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (rel_pending) begin release dut.retire_cnt_q; rel_pending = 1'b0; end
      Ins    = ins;
      Branch = (k == K_BR) ? br : 1'($urandom);
      MemAck = (acks[c] == 2) ? 1'($urandom) : 1'(acks[c]);
    end
  endtask

  // Assert reset mid-cycle and check that it takes effect at once.
  task automatic reset_check(input string name);
    @(negedge clk); #1;
    mon_en = 1'b0;
    MemAck = 1'b0;
    rst_n  = 1'b0;
    #1;
    n_tests++;
    if ({State, MemReq, IorD, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite,
         FlagWrite, OutEn, Halt, IllegalOp, RetireCnt} != '0) begin
      n_fail++;
      $display("FAIL %s: state=%0d memreq=%b halt=%b rc=%h, required all zero",
               name, State, MemReq, Halt, RetireCnt);
    end
    exp_q.delete();
    mcnt = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 mon_en = 1'b1;
  endtask

  task automatic rand_instrs(input int cnt);
    logic [4:0]  ops[17] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                             5'd11, 5'd16, 5'd17, 5'd18, 5'd19, 5'd24, 5'd25, 5'd28};
    logic [15:0] ins;
    logic [2:0]  alu;
    for (int i = 0; i < cnt; i++) begin
      if ($urandom_range(0, 9) == 0) ins = 16'($urandom);
      else ins = {ops[$urandom_range(0, 16)], 11'($urandom)};
      if (classify(ins, alu) == K_HLT) ins[1:0] = 2'b00;   // keep running
      run_instr(ins, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    end
  endtask

  // Monitor: one expected record per cycle while enabled.
  always @(negedge clk) begin
    exp_t        e, a;
    logic [32:0] m;
    if (mon_en) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL underflow: DUT cycle with no expected record, state=%0d", State);
      end else begin
        e = exp_q.pop_front();
        a = '{State, MemReq, IorD, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite,
              FlagWrite, ALUop, OutEn, Halt, IllegalOp, RetireCnt};
        m = '1;
        if (e.st != 3'd2) m[21:19] = 3'b000;   // ALUop only defined in EX
        if ((33'(a) & m) != (33'(e) & m))
          $display("FAIL cycle t=%0t: got st=%0d mr=%b io=%b mw=%b ir=%b pw=%b ps=%b rw=%b fw=%b alu=%0d oe=%b h=%b il=%b rc=%h, want st=%0d mr=%b io=%b mw=%b ir=%b pw=%b ps=%b rw=%b fw=%b alu=%0d oe=%b h=%b il=%b rc=%h",
                   $time, a.st, a.mreq, a.iord, a.mwr, a.irw, a.pcw, a.pcsrc, a.rw, a.fw,
                   a.alu, a.oen, a.hlt, a.ill, a.rc, e.st, e.mreq, e.iord, e.mwr, e.irw,
                   e.pcw, e.pcsrc, e.rw, e.fw, e.alu, e.oen, e.hlt, e.ill, e.rc);
        if ((33'(a) & m) != (33'(e) & m)) n_fail++;
      end
    end
  end

  initial begin
    #12;
    n_tests++;
    if ({State, MemReq, IRWrite, PCWrite, RegWrite, Halt, IllegalOp, RetireCnt} != '0) begin
      n_fail++;
      $display("FAIL reset_init: state=%0d memreq=%b rc=%h, required all zero",
               State, MemReq, RetireCnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 mon_en = 1'b1;

    run_instr(16'h0000, 1'b0, 0, 0, 0, 0);   // ADD, zero-wait fetch
    run_instr(16'h1800, 1'b0, 3, 3, 0, 0);   // LDRri, 3-cycle waits
    run_instr(16'hC300, 1'b0, 0, 0, 0, 0);   // Bcc not taken
    run_instr(16'hC300, 1'b1, 0, 0, 0, 0);   // Bcc taken
    run_instr(16'h8800, 1'b0, 0, 0, 0, 0);   // JALrl
    run_instr(16'h3001, 1'b0, 1, 0, 0, 0);   // CMP
    run_instr(16'h2801, 1'b0, 0, 2, 0, 0);   // STRri
    run_instr(16'hE000, 1'b0, 0, 0, 0, 0);   // OutR
    run_instr(16'h6800, 1'b0, 0, 0, 0, 0);   // undefined opcode

    // Preload the counter just below wrap while the DUT is between
    // instructions (the previous one was illegal, so no retire edge is near).
    @(negedge clk); #1;
    force dut.retire_cnt_q = 16'hFFFF;
    mcnt = 16'hFFFF;
    rel_pending = 1'b1;
    run_instr(16'h0002, 1'b0, 0, 0, 0, 0);   // SUB retires -> wraps to 0
    run_instr(16'h3800, 1'b0, 0, 0, 0, 0);   // ADDI, shows wrapped count

    rand_instrs(120);

    // Reset in MEM with MemReq high.
    run_instr(16'h2800, 1'b0, 0, 5, 0, 5);
    reset_check("reset_mem");

    rand_instrs(60);

    // HLT: sticky Halt, no memory traffic, then reset recovers.
    run_instr(16'hE001, 1'b0, 1, 0, 25, 0);
    reset_check("reset_halt");
    run_instr(16'h5800, 1'b0, 0, 0, 0, 0);   // MOV after reset

    @(negedge clk); #1;
    mon_en = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
